k007232_rom_bridge: RTL
=======================

K007232_ROM_BRIDGE -- requirements
Module: k007232_rom_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000, meaning the byte offset of the sample ROM image in external memory.
REQ-002 SHALL have parameter MEM_AW, default 24, meaning the external memory address width, with MEM_AW >= 17.
REQ-003 i_EMUCLK  in  1  single emulator master clock; all state is clocked on its rising edge.
REQ-004 i_RST_n  in  1  reset, asynchronous and active-low.
REQ-005 i_PCEN  in  1  positive clock enable; address capture and sample-window tracking advance only on cycles where it is high.
REQ-006 i_SA  in  17  multiplexed sample address from the player.
REQ-007 i_SEL  in  1  address phase: 0 = channel A address on i_SA, 1 = channel B address on i_SA.
REQ-008 o_RAM  out  8  sample byte returned to the player for the channel selected by i_SEL.
REQ-009 o_MEM_REQ  out  1  external memory read request, level signal.
REQ-010 o_MEM_ADDR  out  MEM_AW  external read address.
REQ-011 i_MEM_ACK  in  1  one-cycle acknowledge; i_MEM_DATA is valid in the same cycle.
REQ-012 i_MEM_DATA  in  8  external read data.
REQ-013 o_LATE  out  2  one-cycle pulse when a channel's sample window closed on data that was not valid; bit0 = A, bit1 = B.

Function
REQ-014 Each channel SHALL hold these registers: tag[16:0], tag_ok, data[7:0], valid, and pend.
REQ-015 On an i_PCEN cycle, the channel selected by i_SEL SHALL compare i_SA with its tag; if tag_ok=0 or the values differ, it SHALL load tag=i_SA, set tag_ok=1, clear valid, and set pend.
REQ-016 When i_SA matches a valid tag, the channel SHALL NOT issue a new request (hit); data and valid are kept.
REQ-017 The request FSM SHALL have three states: IDLE, BUSY_A, BUSY_B.
REQ-018 IDLE behaviour:
  - only pendA set -> BUSY_A; only pendB set -> BUSY_B.
  - both set -> serve the channel not served last (round-robin); after reset the last-served flag is B.
  - neither set -> stay in IDLE.
REQ-019 On entry to BUSY_x, the FSM SHALL latch fly_addr=tag_x, drive o_MEM_REQ=1, and drive o_MEM_ADDR=BASE_ADDR+fly_addr zero-extended to MEM_AW bits, wrapping modulo 2^MEM_AW.
REQ-020 o_MEM_REQ and o_MEM_ADDR SHALL remain stable until i_MEM_ACK; o_MEM_REQ SHALL deassert in the cycle after ACK, and the FSM returns to IDLE.
REQ-021 On ACK with fly_addr==tag_x, the channel SHALL load data_x=i_MEM_DATA, set valid_x=1, clear pend_x, and update the last-served flag to x.
REQ-022 On ACK with fly_addr!=tag_x (the tag changed in flight), the data SHALL be discarded, pend_x SHALL stay set, and the channel is re-requested through the normal arbitration.
REQ-023 A tag update and an ACK for the same channel in the same cycle SHALL resolve with the tag update winning: the ACK data is discarded and pend stays 1.
REQ-024 i_MEM_ACK received in IDLE SHALL be ignored.
REQ-025 o_RAM SHALL be combinational: i_SEL ? dataB : dataA.
REQ-026 On an i_PCEN cycle where i_SEL rises 0->1 and validA=0, o_LATE[0] SHALL pulse for one cycle; where i_SEL falls 1->0 and validB=0, o_LATE[1] SHALL pulse. The previous i_SEL value is registered on i_PCEN.
REQ-027 Fetch latency is 2 i_EMUCLK cycles plus the memory wait time, measured from pend set to valid set when the FSM is idle.

Reset
REQ-028 Asserting i_RST_n low, including mid-request, SHALL immediately set:
  - FSM=IDLE, o_MEM_REQ=0, o_MEM_ADDR=BASE_ADDR;
  - tag_ok, valid, and pend cleared for both channels; data=0, so o_RAM=0;
  - o_LATE=0, registered previous i_SEL=0, last-served=B.
REQ-029 An i_MEM_ACK that arrives after reset is released, belonging to an aborted request, SHALL be ignored because the FSM is in IDLE.

Structure
REQ-030 Package k007232_pkg SHALL hold the FSM state type (IDLE/BUSY_A/BUSY_B), the sample address width constant (17), and the data width constant (8).
REQ-031 The per-channel tag/data/valid/pend logic SHALL be one sub-module, k007232_rom_slot, instantiated twice.

Verification
REQ-032 Reset, then i_SEL=0, i_SA=17'h00010 on i_PCEN -> o_MEM_REQ=1 with o_MEM_ADDR=BASE_ADDR+16'h10; ACK with data 8'h5A -> o_RAM=8'h5A while i_SEL=0.
REQ-033 Repeat i_SA=17'h00010 on channel A -> no new o_MEM_REQ; o_RAM stays 8'h5A.
REQ-034 A=17'h00020 and B=17'h1FFFF both pending after reset -> first request goes to A, second to B at BASE_ADDR+17'h1FFFF; with BASE_ADDR=24'hFF0000 the address wraps to 24'h00FFFF.
REQ-035 A requests 17'h00030; before ACK, channel A presents 17'h00031 -> ACK data discarded, a second request is issued for 17'h00031, and valid is set only after its ACK.
REQ-036 Memory withholds ACK; i_SEL toggles 0->1 on i_PCEN -> o_LATE=2'b01 for exactly one cycle.
REQ-037 Assert i_RST_n low while o_MEM_REQ=1, release, then pulse i_MEM_ACK -> o_MEM_REQ=0, no valid set, o_RAM=0.

Source files
------------

// File: rtl/k007232_pkg.sv
// Shared widths and the request FSM state type for the K007232 sample ROM bridge.
package k007232_pkg;

  localparam int SA_W = 17;  // sample address width from the player
  localparam int D_W  = 8;   // sample data width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

endpackage

// File: rtl/k007232_rom_slot.sv
// One sample channel: tracks the last address the player asked for, holds the
// fetched byte, and flags when a fetch is still owed for the current tag.
module k007232_rom_slot
  import k007232_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcen,
  input  logic            selected,   // i_SEL currently points at this channel
  input  logic [SA_W-1:0] sa,
  input  logic            ack,        // memory ACK for a request issued on behalf of this channel
  input  logic [SA_W-1:0] fly_addr,   // address of the request currently in flight
  input  logic [D_W-1:0]  mem_data,
  output logic [SA_W-1:0] tag,
  output logic            valid,
  output logic            pend,
  output logic [D_W-1:0]  data,
  output logic            served      // this cycle's ACK is accepted into data
);

  logic tag_ok;
  logic upd;

  // A new address (or the first one after reset) retags the channel. The tag
  // update takes priority over a same-cycle ACK, whose data is then stale.
  assign upd    = pcen && selected && (!tag_ok || (sa != tag));
  assign served = ack && !upd && (fly_addr == tag);

  // Tag/data/valid/pend bookkeeping; an ACK for a superseded tag leaves pend set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag    <= '0;
      tag_ok <= 1'b0;
      valid  <= 1'b0;
      pend   <= 1'b0;
      data   <= '0;
    end else if (upd) begin
      tag    <= sa;
      tag_ok <= 1'b1;
      valid  <= 1'b0;
      pend   <= 1'b1;
    end else if (served) begin
      data  <= mem_data;
      valid <= 1'b1;
      pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/k007232_rom_bridge.sv
// Bridges the K007232 multiplexed sample address bus to a single external
// memory read port, caching one byte per channel and arbitrating refills.
// Memory handshake: o_MEM_REQ rises with a stable o_MEM_ADDR and both hold
// until a one-cycle i_MEM_ACK (data valid that cycle); REQ drops the next cycle.
module k007232_rom_bridge
  import k007232_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int          MEM_AW    = 24
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST_n,
  input  logic              i_PCEN,
  input  logic [SA_W-1:0]   i_SA,
  input  logic              i_SEL,
  output logic [D_W-1:0]    o_RAM,
  output logic              o_MEM_REQ,
  output logic [MEM_AW-1:0] o_MEM_ADDR,
  input  logic              i_MEM_ACK,
  input  logic [D_W-1:0]    i_MEM_DATA,
  output logic [1:0]        o_LATE
);

  state_t          state, state_nx;
  logic [SA_W-1:0] fly_addr, fly_nx;
  logic            last_b;
  logic            prev_sel;
  logic [SA_W-1:0] tag_a, tag_b;
  logic            valid_a, valid_b, pend_a, pend_b, served_a, served_b;
  logic [D_W-1:0]  data_a, data_b;
  logic            ack_a, ack_b;

  assign ack_a = i_MEM_ACK && (state == BUSY_A);
  assign ack_b = i_MEM_ACK && (state == BUSY_B);

  k007232_rom_slot u_slot_a (
    .clk      (i_EMUCLK),
    .rst_n    (i_RST_n),
    .pcen     (i_PCEN),
    .selected (!i_SEL),
    .sa       (i_SA),
    .ack      (ack_a),
    .fly_addr (fly_addr),
    .mem_data (i_MEM_DATA),
    .tag      (tag_a),
    .valid    (valid_a),
    .pend     (pend_a),
    .data     (data_a),
    .served   (served_a)
  );

  k007232_rom_slot u_slot_b (
    .clk      (i_EMUCLK),
    .rst_n    (i_RST_n),
    .pcen     (i_PCEN),
    .selected (i_SEL),
    .sa       (i_SA),
    .ack      (ack_b),
    .fly_addr (fly_addr),
    .mem_data (i_MEM_DATA),
    .tag      (tag_b),
    .valid    (valid_b),
    .pend     (pend_b),
    .data     (data_b),
    .served   (served_b)
  );

  // Next-state: round-robin between pending channels, latch the tag on entry.
  always_comb begin
    state_nx = state;
    fly_nx   = fly_addr;
    case (state)
      IDLE: begin
        if (pend_a && (!pend_b || last_b)) begin
          state_nx = BUSY_A;
          fly_nx   = tag_a;
        end else if (pend_b) begin
          state_nx = BUSY_B;
          fly_nx   = tag_b;
        end
      end
      BUSY_A, BUSY_B: begin
        if (i_MEM_ACK) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and in-flight address.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state    <= IDLE;
      fly_addr <= '0;
    end else begin
      state    <= state_nx;
      fly_addr <= fly_nx;
    end
  end

  // Last-served flag moves only on an accepted fetch; B after reset so A wins first.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n)      last_b <= 1'b1;
    else if (served_a) last_b <= 1'b0;
    else if (served_b) last_b <= 1'b1;
  end

  // Window-close detection: a phase change means the previous channel's slot closed.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      prev_sel <= 1'b0;
      o_LATE   <= 2'b00;
    end else if (i_PCEN) begin
      prev_sel <= i_SEL;
      o_LATE   <= {(!i_SEL && prev_sel && !valid_b), (i_SEL && !prev_sel && !valid_a)};
    end else begin
      o_LATE <= 2'b00;
    end
  end

  assign o_MEM_REQ  = (state != IDLE);
  assign o_MEM_ADDR = MEM_AW'(BASE_ADDR) + MEM_AW'(fly_addr);
  assign o_RAM      = i_SEL ? data_b : data_a;

endmodule
